// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - voice slot allocator: scans the slot table per event, issues press/release/keypress strobes.
// Optional VOICE_ALLOC_STEAL_EN: steal releasing/held slots on exhaustion; otherwise drop and set sticky dropped.
module voice_alloc #(
  parameter int NUM_VOICES = 16,
  parameter int ADDR_W     = 8,
  parameter int STAMP_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_valid,
  output logic              evt_ready,
  input  logic [1:0]        evt_type,
  input  logic [3:0]        evt_channel,
  input  logic [6:0]        evt_note,
  input  logic [6:0]        evt_velocity,
  input  logic              voice_done,
  input  logic [ADDR_W-1:0] voice_done_addr,
  output logic              note_pressed,
  output logic              note_released,
  output logic              note_keypress,
  output logic [ADDR_W-1:0] addr,
  output logic [6:0]        note,
  output logic [6:0]        velocity,
  output logic [3:0]        channel,
  output logic              stolen,
  output logic              dropped
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [ADDR_W:0]  NV_EXT   = (ADDR_W + 1)'(NUM_VOICES);
  localparam logic [1:0] EV_ON  = 2'd0;
  localparam logic [1:0] EV_OFF = 2'd1;
  localparam logic [1:0] EV_KP  = 2'd2;
  localparam logic [1:0] EV_NOP = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ISSUE} fsm_t;
  typedef enum logic [1:0] {SL_FREE, SL_HELD, SL_REL} slot_t;

  fsm_t               state;
  slot_t              slot_state [NUM_VOICES];
  logic [3:0]         slot_ch    [NUM_VOICES];
  logic [6:0]         slot_note  [NUM_VOICES];
  logic [STAMP_W-1:0] slot_stamp [NUM_VOICES];

  logic [IDX_W-1:0]   scan_idx;
  logic [STAMP_W-1:0] seq;
  logic [1:0]         ev_type;
  logic [3:0]         ev_ch;
  logic [6:0]         ev_note;
  logic [6:0]         ev_vel;

  logic               m_found, f_found, r_found, h_found;
  logic [IDX_W-1:0]   m_idx, f_idx, r_idx, h_idx;
  logic [STAMP_W-1:0] r_age, h_age;

  slot_t              cur_st;
  logic [STAMP_W-1:0] cur_age;
  logic               cur_match;
  logic               done_hit;
  logic [IDX_W-1:0]   done_idx;
  logic               sel_ok, sel_steal;
  logic [IDX_W-1:0]   sel_idx;

  assign cur_st    = slot_state[scan_idx];
  assign cur_age   = seq - slot_stamp[scan_idx];
  assign cur_match = (slot_ch[scan_idx] == ev_ch) && (slot_note[scan_idx] == ev_note) &&
                     ((cur_st == SL_HELD) || ((ev_type == EV_KP) && (cur_st == SL_REL)));
  assign done_idx  = voice_done_addr[IDX_W-1:0];
  assign done_hit  = voice_done && ({1'b0, voice_done_addr} < NV_EXT);

  always_comb begin
    sel_ok    = 1'b0;
    sel_steal = 1'b0;
    sel_idx   = m_idx;
    if (ev_type == EV_ON) begin
      if (m_found) begin
        sel_ok = 1'b1;
      end else if (f_found) begin
        sel_ok  = 1'b1;
        sel_idx = f_idx;
      end
`ifdef VOICE_ALLOC_STEAL_EN
      else if (r_found) begin
        sel_ok    = 1'b1;
        sel_steal = 1'b1;
        sel_idx   = r_idx;
      end else if (h_found) begin
        sel_ok    = 1'b1;
        sel_steal = 1'b1;
        sel_idx   = h_idx;
      end
`endif
    end else begin
      sel_ok = m_found;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      evt_ready     <= 1'b1;
      note_pressed  <= 1'b0;
      note_released <= 1'b0;
      note_keypress <= 1'b0;
      addr          <= '0;
      note          <= '0;
      velocity      <= '0;
      channel       <= '0;
      stolen        <= 1'b0;
      dropped       <= 1'b0;
      seq           <= '0;
      scan_idx      <= '0;
      ev_type       <= EV_ON;
      ev_ch         <= '0;
      ev_note       <= '0;
      ev_vel        <= '0;
      m_found       <= 1'b0;
      f_found       <= 1'b0;
      r_found       <= 1'b0;
      h_found       <= 1'b0;
      m_idx         <= '0;
      f_idx         <= '0;
      r_idx         <= '0;
      h_idx         <= '0;
      r_age         <= '0;
      h_age         <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        slot_state[i] <= SL_FREE;
        slot_ch[i]    <= '0;
        slot_note[i]  <= '0;
        slot_stamp[i] <= '0;
      end
    end else begin
      note_pressed  <= 1'b0;
      note_released <= 1'b0;
      note_keypress <= 1'b0;

      // Issue-stage table writes below come later and therefore override this free.
      if (done_hit && (slot_state[done_idx] == SL_REL))
        slot_state[done_idx] <= SL_FREE;

      case (state)
        ST_IDLE: begin
          if (evt_valid && (evt_type != EV_NOP)) begin
            ev_type   <= ((evt_type == EV_ON) && (evt_velocity == 7'd0)) ? EV_OFF : evt_type;
            ev_ch     <= evt_channel;
            ev_note   <= evt_note;
            ev_vel    <= evt_velocity;
            scan_idx  <= '0;
            m_found   <= 1'b0;
            f_found   <= 1'b0;
            r_found   <= 1'b0;
            h_found   <= 1'b0;
            evt_ready <= 1'b0;
            state     <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (cur_match && !m_found) begin
            m_found <= 1'b1;
            m_idx   <= scan_idx;
          end
          case (cur_st)
            SL_FREE: if (!f_found) begin
              f_found <= 1'b1;
              f_idx   <= scan_idx;
            end
            SL_HELD: if (!h_found || (cur_age > h_age)) begin
              h_found <= 1'b1;
              h_idx   <= scan_idx;
              h_age   <= cur_age;
            end
            SL_REL: if (!r_found || (cur_age > r_age)) begin
              r_found <= 1'b1;
              r_idx   <= scan_idx;
              r_age   <= cur_age;
            end
            default: ;
          endcase
          if (scan_idx == LAST_IDX) state <= ST_ISSUE;
          else                      scan_idx <= scan_idx + 1'b1;
        end

        ST_ISSUE: begin
          if (sel_ok) begin
            addr     <= ADDR_W'(sel_idx);
            note     <= ev_note;
            velocity <= ev_vel;
            channel  <= ev_ch;
            case (ev_type)
              EV_ON: begin
                note_pressed          <= 1'b1;
                stolen                <= sel_steal;
                slot_state[sel_idx]   <= SL_HELD;
                slot_ch[sel_idx]      <= ev_ch;
                slot_note[sel_idx]    <= ev_note;
                slot_stamp[sel_idx]   <= seq;
                seq                   <= seq + 1'b1;
              end
              EV_OFF: begin
                note_released         <= 1'b1;
                slot_state[sel_idx]   <= SL_REL;
              end
              default: note_keypress  <= 1'b1;
            endcase
          end else if (ev_type == EV_ON) begin
            dropped <= 1'b1;
          end
          evt_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// tb/tb_voice_alloc.sv - directed-vector bench for voice_alloc (default NUM_VOICES=16).
module tb_voice_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       evt_valid = 1'b0;
  logic       evt_ready;
  logic [1:0] evt_type = 2'd0;
  logic [3:0] evt_channel = 4'd0;
  logic [6:0] evt_note = 7'd0;
  logic [6:0] evt_velocity = 7'd0;
  logic       voice_done = 1'b0;
  logic [7:0] voice_done_addr = 8'd0;
  logic       note_pressed, note_released, note_keypress, stolen, dropped;
  logic [7:0] addr;
  logic [6:0] note, velocity;
  logic [3:0] channel;

  int checks = 0;
  int failures = 0;

  logic       r_press, r_rel, r_kp, r_stolen, r_after;
  logic [7:0] r_addr;
  logic [6:0] r_note, r_vel;
  logic [3:0] r_ch;
  int         r_busy;
  logic       done_at_issue = 1'b0;
  logic [7:0] done_issue_addr = 8'd0;
  int         late_press;

  voice_alloc dut (
    .clk(clk), .rst(rst),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_channel(evt_channel), .evt_note(evt_note), .evt_velocity(evt_velocity),
    .voice_done(voice_done), .voice_done_addr(voice_done_addr),
    .note_pressed(note_pressed), .note_released(note_released), .note_keypress(note_keypress),
    .addr(addr), .note(note), .velocity(velocity), .channel(channel),
    .stolen(stolen), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_evt(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] n, input logic [6:0] v);
    int cnt;
    @(negedge clk);
    evt_valid = 1'b1; evt_type = t; evt_channel = ch; evt_note = n; evt_velocity = v;
    cnt = 0;
    while (!evt_ready && cnt < 100) begin @(negedge clk); cnt++; end
    @(negedge clk);
    evt_valid = 1'b0;
    cnt = 0;
    while (!evt_ready && cnt < 40) begin
      cnt++;
      if (done_at_issue && cnt == 17) begin
        voice_done = 1'b1; voice_done_addr = done_issue_addr;
      end
      @(negedge clk);
    end
    voice_done = 1'b0;
    if (cnt >= 40) check("evt_timeout", cnt, 17);
    r_busy = cnt;
    r_press = note_pressed; r_rel = note_released; r_kp = note_keypress;
    r_stolen = stolen; r_addr = addr; r_note = note; r_vel = velocity; r_ch = channel;
    @(negedge clk);
    r_after = note_pressed | note_released | note_keypress;
  endtask

  task automatic vdone(input logic [7:0] a);
    @(negedge clk);
    voice_done = 1'b1; voice_done_addr = a;
    @(negedge clk);
    voice_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", evt_ready, 1);
    check("rst_strobes", {note_pressed, note_released, note_keypress, stolen, dropped}, 0);
    check("rst_addr", addr, 0);
    rst = 1'b0;

    do_evt(2'd0, 4'd0, 7'd60, 7'd100);
    check("on60_busy", r_busy, 17);
    check("on60_press", {r_press, r_rel, r_kp}, 3'b100);
    check("on60_addr", r_addr, 0);
    check("on60_note", r_note, 60);
    check("on60_vel", r_vel, 100);
    check("on60_stolen", r_stolen, 0);
    check("on60_one_cycle", r_after, 0);

    do_evt(2'd0, 4'd0, 7'd62, 7'd90);
    check("on62_addr", {r_press, r_addr}, {1'b1, 8'd1});
    do_evt(2'd1, 4'd0, 7'd62, 7'd40);
    check("off62_rel", {r_press, r_rel, r_kp}, 3'b010);
    check("off62_addr", r_addr, 1);
    do_evt(2'd1, 4'd1, 7'd62, 7'd40);
    check("off62_ch1_none", {r_press, r_rel, r_kp}, 0);

    do_evt(2'd0, 4'd0, 7'd64, 7'd0);
    check("on64v0_none", {r_press, r_rel, r_kp}, 0);
    do_evt(2'd0, 4'd0, 7'd64, 7'd80);
    check("on64_addr", {r_press, r_addr}, {1'b1, 8'd2});
    do_evt(2'd0, 4'd0, 7'd64, 7'd0);
    check("on64v0_rel", {r_press, r_rel, r_kp, r_addr}, {3'b010, 8'd2});

    do_evt(2'd2, 4'd0, 7'd60, 7'd55);
    check("kp60", {r_press, r_rel, r_kp, r_addr, 1'b0, r_vel}, {3'b001, 8'd0, 8'd55});
    do_evt(2'd2, 4'd0, 7'd99, 7'd55);
    check("kp99_none", {r_press, r_rel, r_kp}, 0);
    do_evt(2'd3, 4'd0, 7'd60, 7'd55);
    check("type3_none", {r_press, r_rel, r_kp, 8'(r_busy)}, 0);

    do_evt(2'd0, 4'd0, 7'd60, 7'd70);
    check("retrig60", {r_press, r_addr, r_stolen}, {1'b1, 8'd0, 1'b0});

    vdone(8'd1);
    vdone(8'd0);
    vdone(8'd200);
    do_evt(2'd0, 4'd2, 7'd10, 7'd20);
    check("on_after_done", {r_press, r_addr, r_ch}, {1'b1, 8'd1, 4'd2});
    vdone(8'd2);

    for (int i = 0; i < 14; i++) begin
      do_evt(2'd0, 4'd3, 7'(20 + i), 7'd10);
      check("fill", {r_press, r_addr}, {1'b1, 8'(2 + i)});
    end
    do_evt(2'd1, 4'd3, 7'd23, 7'd0);
    check("off_slot5", {r_rel, r_addr}, {1'b1, 8'd5});

`ifdef VOICE_ALLOC_STEAL_EN
    do_evt(2'd0, 4'd0, 7'd70, 7'd1);
    check("steal_rel", {r_press, r_addr, r_stolen}, {1'b1, 8'd5, 1'b1});
    do_evt(2'd0, 4'd0, 7'd71, 7'd1);
    check("steal_held", {r_press, r_addr, r_stolen}, {1'b1, 8'd0, 1'b1});
    do_evt(2'd1, 4'd0, 7'd70, 7'd0);
    check("off70", {r_rel, r_addr}, {1'b1, 8'd5});
    vdone(8'd5);
    do_evt(2'd0, 4'd0, 7'd72, 7'd1);
    check("reuse5", {r_press, r_addr, r_stolen}, {1'b1, 8'd5, 1'b0});
`else
    do_evt(2'd0, 4'd0, 7'd70, 7'd1);
    check("drop_none", {r_press, r_rel, r_kp}, 0);
    check("drop_flag", dropped, 1);
    vdone(8'd5);
    do_evt(2'd0, 4'd0, 7'd70, 7'd1);
    check("reuse5", {r_press, r_addr, r_stolen}, {1'b1, 8'd5, 1'b0});
    check("drop_sticky", dropped, 1);
`endif

    vdone(8'd3);
    do_evt(2'd1, 4'd3, 7'd21, 7'd0);
    check("done_held_kept", {r_rel, r_addr}, {1'b1, 8'd3});
    do_evt(2'd1, 4'd3, 7'd24, 7'd0);
    check("off_slot6", {r_rel, r_addr}, {1'b1, 8'd6});
    vdone(8'd6);
    done_at_issue = 1'b1; done_issue_addr = 8'd6;
    do_evt(2'd0, 4'd4, 7'd50, 7'd33);
    done_at_issue = 1'b0;
    check("issue_vs_done", {r_press, r_addr}, {1'b1, 8'd6});
    do_evt(2'd1, 4'd4, 7'd50, 7'd0);
    check("issue_wins_rel", {r_rel, r_addr}, {1'b1, 8'd6});
`ifdef VOICE_ALLOC_STEAL_EN
    check("dropped_end", dropped, 0);
`else
    check("dropped_end", dropped, 1);
`endif

    @(negedge clk);
    evt_valid = 1'b1; evt_type = 2'd0; evt_channel = 4'd5; evt_note = 7'd1; evt_velocity = 7'd1;
    @(negedge clk);
    evt_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", evt_ready, 1);
    check("midrst_dropped", dropped, 0);
    rst = 1'b0;
    late_press = 0;
    repeat (25) begin
      @(negedge clk);
      if (note_pressed) late_press++;
    end
    check("midrst_no_strobe", late_press, 0);
    do_evt(2'd0, 4'd5, 7'd2, 7'd3);
    check("after_rst", {r_press, r_addr, r_stolen, 8'(r_busy)}, {1'b1, 8'd0, 1'b0, 8'd17});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Voice allocator/scheduler in front of the synth voice RAM; it owns slot assignment for every note event.
- Turns decoded MIDI events (note on, note off, poly keypress) into single-cycle press/release/keypress strobes plus a voice slot address for the synth core.
- Tracks each slot's occupancy (free/held/releasing) and frees slots when the synth reports end of release.
- On exhaustion it steals a slot: oldest releasing voice first, then oldest held voice.

Parameters:
NUM_VOICES, 16, number of managed slots (2..256); slots 0..NUM_VOICES-1 used
ADDR_W, 8, width of slot address output
STAMP_W, 12, width of allocation sequence stamp

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
evt_valid  in  1  event present
evt_ready  out  1  allocator idle, event accepted when evt_valid&evt_ready
evt_type  in  2  0=note_on, 1=note_off, 2=keypress, 3=ignored
evt_channel  in  4  MIDI channel
evt_note  in  7  MIDI note
evt_velocity  in  7  velocity / pressure
voice_done  in  1  synth reports release finished for voice_done_addr
voice_done_addr  in  ADDR_W  slot that reached silence
note_pressed  out  1  one-cycle strobe, start voice
note_released  out  1  one-cycle strobe, release voice
note_keypress  out  1  one-cycle strobe, pressure update
addr  out  ADDR_W  target slot, valid with any strobe
note  out  7  note for strobe
velocity  out  7  velocity for strobe
channel  out  4  channel for strobe
stolen  out  1  with note_pressed: slot was taken from an active voice

Behaviour:
- Async reset: all slots FREE; all strobes, stolen, addr, note, velocity, channel = 0; evt_ready=1; seq counter=0; FSM=IDLE.
- Per-slot table: state {FREE, HELD, RELEASING}, channel, note, stamp[STAMP_W].
- FSM states:
  - IDLE: evt_ready=1. Accept -> latch event -> SCAN. Type 3 is consumed with no output and stays IDLE. note_on with velocity 0 is converted to note_off at latch.
  - SCAN: evt_ready=0; visits one slot per cycle, index 0..NUM_VOICES-1 (exactly NUM_VOICES cycles), tracking:
    - match: first HELD slot with equal channel/note; for note_off and keypress also accept RELEASING for keypress only
    - first FREE slot
    - oldest RELEASING slot
    - oldest HELD slot
  - ISSUE: one cycle; drives one strobe plus addr/note/velocity/channel; updates table; -> IDLE.
- Age rule: age = (seq - stamp) mod 2^STAMP_W; largest age is oldest; ties go to the lower index. seq increments on every note_pressed issue, and the slot stamp is set to the pre-increment seq.
- note_on selection priority: match (retrigger same slot, stolen=0) > first FREE > oldest RELEASING (stolen=1) > oldest HELD (stolen=1). Issue note_pressed; slot -> HELD with new channel/note.
- note_off: match found -> note_released with the matched slot's addr, slot -> RELEASING; no match -> no strobe.
- keypress: HELD match -> note_keypress, table unchanged; no match -> no strobe.
- Latency: accept to strobe = NUM_VOICES+1 cycles. Outputs other than strobes hold their last value between strobes.
- voice_done:
  - Honoured in any state: a RELEASING slot -> FREE. No effect on FREE or HELD slots; a retriggered voice is never freed by a stale done.
  - Ignored when voice_done_addr >= NUM_VOICES.
  - If it coincides with ISSUE writing the same slot, ISSUE wins.
  - A slot freed during SCAN after the scanner has passed it is not seen until the next event.
- evt_valid while evt_ready=0: not consumed; upstream must hold it.
- Reset mid-scan: abort the event, no strobe.

Optional Feature:
VOICE_ALLOC_STEAL_EN
- Defined: stealing as above.
- Undefined: note_on with no match and no FREE slot issues no strobe; a sticky `dropped` output (1 bit, reset 0, cleared by rst only) is set, and stolen is tied to 0.

Test Plan:
- Reset, then note_on ch0 n60 v100 -> after 17 cycles: note_pressed=1, addr=0, note=60, velocity=100, stolen=0; evt_ready low for those 17 cycles.
- note_on n60, n62, then note_off ch0 n62 -> note_released addr=1; note_off ch1 n62 -> no strobe.
- note_on ch0 n64 v0 -> treated as note_off; with no match, no strobe, and a held n64 gets note_released.
- Fill 16 slots, note_off on slot 5, then note_on n70 -> addr=5, stolen=1 (RELEASING preferred). Repeat with no releases -> addr=0 (oldest HELD). After voice_done addr=5 -> next note_on addr=5, stolen=0.
- Macro undefined: 17th note_on -> no strobe, dropped=1 and sticky until reset.
- voice_done for a HELD slot and voice_done on the same slot in its ISSUE cycle -> slot remains HELD; a later note_off on it still yields note_released.
